// File: rtl/axi4lite_req_frontend_if.sv
// Bus bundle between the AXI4-Lite slave front end and its neighbours: the AXI4-Lite
// master on one side, the APB master stage request/status port on the other.
interface axi4lite_req_frontend_if;
  // AXI4-Lite write address / write data / write response
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  // AXI4-Lite read address / read data
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  // Request port of the APB master stage plus APB bus taps
  logic        STREQ;
  logic        SWRT;
  logic        SSEL;
  logic [31:0] SADDR;
  logic [31:0] SWDATA;
  logic [31:0] SRDATA;
  logic [1:0]  Out_State;
  logic        PREADY;
  logic        PSLVERR;

  // View of the front end itself
  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    input  SRDATA, Out_State, PREADY, PSLVERR,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
    output STREQ, SWRT, SSEL, SADDR, SWDATA
  );

  // View of the surrounding environment (AXI master and APB master stage)
  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    output SRDATA, Out_State, PREADY, PSLVERR,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
    input  STREQ, SWRT, SSEL, SADDR, SWDATA
  );
endinterface

// File: rtl/axi4lite_req_frontend.sv
// AXI4-Lite slave front end of the AXI4-Lite-to-APB bridge. Buffers one AW, one W and
// one AR beat, arbitrates write vs read with alternating priority on contests, issues a
// single-cycle request to the APB master and returns the B/R response.
module axi4lite_req_frontend #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          WRITE_FIRST = 1'b1
) (
  input logic                   PCLK,
  input logic                   PRESETn,
  axi4lite_req_frontend_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                  r_state;
  state_e                  w_state_next;

  logic                    r_aw_full, r_w_full, r_ar_full;
  logic                    r_awready, r_wready, r_arready;
  logic [ADDR_WIDTH-1:0]   r_aw_addr, r_ar_addr;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic                    r_prio_wr;

  logic [ADDR_WIDTH-1:0]   r_saddr;
  logic [DATA_WIDTH-1:0]   r_swdata;
  logic                    r_swrt, r_ssel;
  logic                    r_bvalid, r_rvalid;
  logic [1:0]              r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic w_aw_hs, w_w_hs, w_ar_hs;
  logic w_aw_full_next, w_w_full_next, w_ar_full_next;
  logic w_wr_cand, w_rd_cand, w_contest;
  logic w_grant_wr, w_grant_rd;
  logic w_done, w_resp_hs;
  logic [1:0] w_resp;
  logic w_unused;

  // Protection and strobes are not forwarded to APB
  assign w_unused = ^{bus.AWPROT, bus.WSTRB, bus.ARPROT};

  assign w_aw_hs   = bus.AWVALID & r_awready;
  assign w_w_hs    = bus.WVALID  & r_wready;
  assign w_ar_hs   = bus.ARVALID & r_arready;
  assign w_wr_cand = r_aw_full & r_w_full;
  assign w_rd_cand = r_ar_full;
  assign w_contest = w_wr_cand & w_rd_cand;
  assign w_done    = (r_state == StWait) && (bus.Out_State == 2'd2) && bus.PREADY;
  assign w_resp_hs = (r_bvalid & bus.BREADY) | (r_rvalid & bus.RREADY);
  assign w_resp    = bus.PSLVERR ? 2'b10 : 2'b00;

  // A slot never captures and gets granted in the same cycle: READY is low while full
  assign w_aw_full_next = (r_aw_full & ~w_grant_wr) | w_aw_hs;
  assign w_w_full_next  = (r_w_full  & ~w_grant_wr) | w_w_hs;
  assign w_ar_full_next = (r_ar_full & ~w_grant_rd) | w_ar_hs;

  // Arbitration: only from IDLE with the APB master idle; priority decides contests
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if ((r_state == StIdle) && (bus.Out_State == 2'd0)) begin
      if (w_contest) begin
        w_grant_wr = r_prio_wr;
        w_grant_rd = ~r_prio_wr;
      end else begin
        w_grant_wr = w_wr_cand;
        w_grant_rd = w_rd_cand;
      end
    end
  end

  // Holding registers; READY is registered so it reads 0 while in reset
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_ar_addr <= '0;
    end else begin
      r_aw_full <= w_aw_full_next;
      r_w_full  <= w_w_full_next;
      r_ar_full <= w_ar_full_next;
      r_awready <= ~w_aw_full_next;
      r_wready  <= ~w_w_full_next;
      r_arready <= ~w_ar_full_next;
      if (w_aw_hs) r_aw_addr <= bus.AWADDR;
      if (w_w_hs)  r_w_data  <= bus.WDATA;
      if (w_ar_hs) r_ar_addr <= bus.ARADDR;
    end
  end

  // FSM state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_wr || w_grant_rd) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (w_done) w_state_next = StResp;
      StResp:  if (w_resp_hs) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs; STREQ is masked in Access so the master cannot re-enter Setup
  always_comb begin
    bus.STREQ = (r_state == StIssue) && (bus.Out_State != 2'd2);
  end

  // Request/response datapath and priority tracking
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prio_wr <= WRITE_FIRST;
      r_saddr   <= '0;
      r_swrt    <= 1'b0;
      r_swdata  <= '0;
      r_ssel    <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      if (w_contest && (w_grant_wr || w_grant_rd)) r_prio_wr <= ~r_prio_wr;
      if (w_grant_wr) begin
        r_saddr  <= r_aw_addr;
        r_swrt   <= 1'b1;
        r_swdata <= r_w_data;
      end else if (w_grant_rd) begin
        r_saddr  <= r_ar_addr;
        r_swrt   <= 1'b0;
      end
      if (r_state == StIssue) r_ssel <= 1'b1;
      if (w_done) begin
        r_ssel <= 1'b0;
        if (r_swrt) begin
          r_bvalid <= 1'b1;
          r_bresp  <= w_resp;
        end else begin
          r_rvalid <= 1'b1;
          r_rresp  <= w_resp;
          r_rdata  <= bus.SRDATA;
        end
      end
      if (r_bvalid && bus.BREADY) r_bvalid <= 1'b0;
      if (r_rvalid && bus.RREADY) r_rvalid <= 1'b0;
    end
  end

  assign bus.AWREADY = r_awready;
  assign bus.WREADY  = r_wready;
  assign bus.ARREADY = r_arready;
  assign bus.BVALID  = r_bvalid;
  assign bus.BRESP   = r_bresp;
  assign bus.RVALID  = r_rvalid;
  assign bus.RRESP   = r_rresp;
  assign bus.RDATA   = r_rdata;
  assign bus.SWRT    = r_swrt;
  assign bus.SSEL    = r_ssel;
  assign bus.SADDR   = r_saddr;
  assign bus.SWDATA  = r_swdata;

endmodule
